// File: rtl/mm_job_sequencer.sv
// Job sequencer for the streaming MM engine: fetches A and B row-major from source
// memory, frames them for the engine, collects results and reports done/errors.
module mm_job_sequencer #(
  parameter int DW  = 8,
  parameter int OW  = 12,
  parameter int AW  = 8,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    a_rows,
  input  logic [2:0]    a_cols,
  input  logic [2:0]    b_rows,
  input  logic [2:0]    b_cols,
  input  logic [AW-1:0] a_base,
  input  logic [AW-1:0] b_base,
  output logic          src_rd,
  output logic [AW-1:0] src_addr,
  input  logic [DW-1:0] src_data,
  output logic [DW-1:0] mm_in_data,
  output logic          mm_col_end,
  output logic          mm_row_end,
  input  logic          mm_valid,
  input  logic [OW-1:0] mm_out_data,
  input  logic [1:0]    mm_ep,
  output logic          res_we,
  output logic [3:0]    res_addr,
  output logic [OW-1:0] res_data,
  output logic          ready,
  output logic          done,
  output logic [4:0]    err,
  output logic [2:0]    dbg_state
);
  // Handshake: start is a request sampled only while ready=1; there is no backpressure
  // on the source or engine side, a read strobe is always answered one cycle later.
  typedef enum logic [2:0] {IDLE, LOAD_A, GAP_A, LOAD_B, COLLECT, DONE} state_t;
  localparam int TW = $clog2(TMO + 1);

  state_t        state, state_nx;
  logic [2:0]    ar_q, ac_q, br_q, bc_q;
  logic [AW-1:0] ab_q, bb_q;
  logic [4:0]    n_res;
  logic [1:0]    row, col;
  logic [3:0]    idx;
  logic          rd_q, col_end_q, row_end_q, mv_q;
  logic [4:0]    wr_cnt;
  logic [TW-1:0] wd;
  logic [4:0]    err_q;
  logic          done_q, res_we_q;
  logic [3:0]    res_addr_q;
  logic [OW-1:0] res_data_q;

  logic          cfg_bad, loading, col_last, row_last, el_last, rise, wr_last, wd_hit;
  logic [2:0]    cur_rows, cur_cols;
  logic [AW-1:0] cur_base;

  assign cfg_bad  = (a_rows == 3'd0) || (a_rows > 3'd4) || (a_cols == 3'd0) || (a_cols > 3'd4) ||
                    (b_rows == 3'd0) || (b_rows > 3'd4) || (b_cols == 3'd0) || (b_cols > 3'd4);
  assign loading  = (state == LOAD_A) || (state == LOAD_B);
  assign cur_rows = (state == LOAD_B) ? br_q : ar_q;
  assign cur_cols = (state == LOAD_B) ? bc_q : ac_q;
  assign cur_base = (state == LOAD_B) ? bb_q : ab_q;
  assign col_last = ({1'b0, col} == cur_cols - 3'd1);
  assign row_last = ({1'b0, row} == cur_rows - 3'd1);
  assign el_last  = col_last && row_last;
  assign rise     = mm_valid && !mv_q;
  assign wr_last  = (wr_cnt + 5'd1 == n_res);
  assign wd_hit   = (wd == TW'(TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = cfg_bad ? DONE : LOAD_A;
      LOAD_A:  if (el_last) state_nx = GAP_A;
      GAP_A:   state_nx = LOAD_B;
      LOAD_B:  if (el_last) state_nx = COLLECT;
      COLLECT: if (rise ? (err_q[2] || wr_last) : wd_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q <= '0; ac_q <= '0; br_q <= '0; bc_q <= '0;
      ab_q <= '0; bb_q <= '0; n_res <= '0;
      row <= '0; col <= '0; idx <= '0;
      rd_q <= 1'b0; col_end_q <= 1'b0; row_end_q <= 1'b0; mv_q <= 1'b0;
      wr_cnt <= '0; wd <= '0; err_q <= '0; done_q <= 1'b0;
      res_we_q <= 1'b0; res_addr_q <= '0; res_data_q <= '0;
    end else begin
      mv_q      <= mm_valid;
      // Framing flags are computed at issue time and delayed to line up with read data.
      rd_q      <= loading;
      col_end_q <= loading && col_last;
      row_end_q <= loading && el_last;
      res_we_q  <= 1'b0;
      done_q    <= (state == DONE);
      if (state == IDLE && start) begin
        ar_q <= a_rows; ac_q <= a_cols; br_q <= b_rows; bc_q <= b_cols;
        ab_q <= a_base; bb_q <= b_base;
        n_res  <= {2'b00, a_rows} * {2'b00, b_cols};
        err_q  <= {1'b0, cfg_bad, !cfg_bad && (a_cols != b_rows), 2'b00};
        row <= '0; col <= '0; idx <= '0; wr_cnt <= '0;
      end
      if (loading) begin
        if (el_last) begin
          row <= '0; col <= '0; idx <= '0;
        end else if (col_last) begin
          col <= '0; row <= row + 2'd1; idx <= idx + 4'd1;
        end else begin
          col <= col + 2'd1; idx <= idx + 4'd1;
        end
      end
      wd <= (state == COLLECT && !rise) ? wd + TW'(1) : '0;
      if (state == COLLECT) begin
        if (rise) begin
          if (err_q[2]) begin
            err_q[1:0] <= mm_ep;
          end else begin
            res_we_q   <= 1'b1;
            res_addr_q <= wr_cnt[3:0];
            res_data_q <= mm_out_data;
            wr_cnt     <= wr_cnt + 5'd1;
          end
        end else if (wd_hit) begin
          err_q[4] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready      = (state == IDLE);
    src_rd     = loading;
    src_addr   = loading ? cur_base + AW'(idx) : '0;
    mm_in_data = rd_q ? src_data : '0;
    mm_col_end = col_end_q;
    mm_row_end = row_end_q;
    res_we     = res_we_q;
    res_addr   = res_addr_q;
    res_data   = res_data_q;
    done       = done_q;
    err        = err_q;
    dbg_state  = state;
  end
endmodule
